// File: rtl/move_sequencer_if.sv
// Handshake bundle between the move sequencer and the players/board.
// slave: sequencer side; master: player/board side.
interface move_sequencer_if;
  logic       start;
  logic       first_player;
  logic       fpga_req;
  logic [2:0] fpga_col;
  logic       ard_req;
  logic [2:0] ard_col;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [1:0] wr_val;
  logic       turn;
  logic [3:0] secs_left;
  logic       reject;
  logic       board_full;

  modport slave (
    input  start, first_player, fpga_req, fpga_col, ard_req, ard_col,
    output wr_en, wr_row, wr_col, wr_val, turn, secs_left, reject, board_full
  );

  modport master (
    output start, first_player, fpga_req, fpga_col, ard_req, ard_col,
    input  wr_en, wr_row, wr_col, wr_val, turn, secs_left, reject, board_full
  );
endinterface

// File: rtl/move_sequencer.sv
// Connect-four move sequencer: turn order, per-turn timer, column heights and board writes.
// Define AUTO_MOVE_EN to auto-play the lowest non-full column on timeout instead of forfeiting.
module move_sequencer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TURN_SECS = 10
) (
  input logic             clk,
  input logic             rst,
  move_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StWaitMove, StCheck, StWrite, StSwap, StFull
  } state_e;

  localparam int unsigned PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);
  localparam logic [3:0]  SecsLoad = 4'(TURN_SECS);
  localparam logic [5:0]  NumCells = 6'd42;

  state_e        state_q, state_d;
  logic          turn_q, turn_d;
  logic [3:0]    secs_q, secs_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    col_q, col_d;
  logic [2:0]    height_q [7];
  logic [2:0]    height_d [7];
  logic [5:0]    moves_q, moves_d;

  logic       cur_full;
  logic [2:0] cur_h;
  logic       col_bad;
  logic       own_req;
  logic [2:0] own_col;
  logic       timing;
  logic       tick;
  logic       go_swap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      turn_q  <= 1'b0;
      secs_q  <= '0;
      presc_q <= '0;
      col_q   <= '0;
      moves_q <= '0;
      for (int i = 0; i < 7; i++) height_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      secs_q   <= secs_d;
      presc_q  <= presc_d;
      col_q    <= col_d;
      moves_q  <= moves_d;
      height_q <= height_d;
    end
  end

  // Height of the latched column; column 7 does not exist and is always illegal.
  always_comb begin
    cur_h = '0;
    for (int i = 0; i < 7; i++) begin
      if (col_q == 3'(i)) cur_h = height_q[i];
    end
    cur_full = (cur_h == 3'd6);
    col_bad  = (col_q == 3'd7) || cur_full;
  end

  assign own_req = turn_q ? bus.ard_req : bus.fpga_req;
  assign own_col = turn_q ? bus.ard_col : bus.fpga_col;

`ifdef AUTO_MOVE_EN
  logic [2:0] auto_col;

  // Scan high to low so the lowest non-full column wins.
  always_comb begin
    auto_col = '0;
    for (int i = 6; i >= 0; i--) begin
      if (height_q[i] != 3'd6) auto_col = 3'(i);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    col_d    = col_q;
    height_d = height_q;
    moves_d  = moves_q;
    go_swap  = 1'b0;

    timing  = (state_q == StWaitMove) || (state_q == StCheck);
    tick    = timing && (presc_q == PrescMax);
    presc_d = presc_q;
    secs_d  = secs_q;
    if (timing) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick && (secs_q != 4'd0)) secs_d = secs_q - 1'b1;
    end

    case (state_q)
      StIdle, StFull: begin
        if (bus.start) begin
          turn_d  = bus.first_player;
          moves_d = '0;
          secs_d  = SecsLoad;
          presc_d = '0;
          for (int i = 0; i < 7; i++) height_d[i] = '0;
          state_d = StWaitMove;
        end
      end
      StWaitMove: begin
        if (own_req) begin
          col_d   = own_col;
          state_d = StCheck;
        end else if (secs_q == 4'd0) begin
`ifdef AUTO_MOVE_EN
          col_d   = auto_col;
          state_d = StWrite;
`else
          go_swap = 1'b1;
`endif
        end
      end
      StCheck: begin
        state_d = col_bad ? StWaitMove : StWrite;
      end
      StWrite: begin
        for (int i = 0; i < 7; i++) begin
          if (col_q == 3'(i)) height_d[i] = height_q[i] + 1'b1;
        end
        moves_d = moves_q + 1'b1;
        go_swap = 1'b1;
      end
      StSwap: begin
        state_d = (moves_q == NumCells) ? StFull : StWaitMove;
      end
      default: state_d = StIdle;
    endcase

    // Turn handover is committed on entry to SWAP so the new player shows up during SWAP.
    if (go_swap) begin
      state_d = StSwap;
      if (moves_d != NumCells) begin
        turn_d  = ~turn_q;
        secs_d  = SecsLoad;
        presc_d = '0;
      end
    end
  end

  always_comb begin
    bus.wr_en      = (state_q == StWrite);
    bus.wr_row     = bus.wr_en ? cur_h : 3'd0;
    bus.wr_col     = bus.wr_en ? col_q : 3'd0;
    bus.wr_val     = bus.wr_en ? (turn_q ? 2'b10 : 2'b01) : 2'b00;
    bus.reject     = (state_q == StCheck) && col_bad;
    bus.board_full = (state_q == StFull);
    bus.turn       = turn_q;
    bus.secs_left  = secs_q;
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: table of moves plus model-driven sequences, writes scoreboarded.
module tb_move_sequencer;

  localparam int unsigned CLK_HZ    = 16;
  localparam int unsigned TURN_SECS = 2;
  localparam int KW = 0;  // legal write
  localparam int KR = 1;  // reject
  localparam int KI = 2;  // ignored

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] val;
  } wr_t;

  typedef struct {
    bit         p;
    logic [2:0] col;
    int         kind;
    logic [2:0] row;
    logic [1:0] val;
    bit         turn_after;
  } vec_t;

  logic clk;
  logic rst;
  move_sequencer_if bus_if ();

  move_sequencer #(
    .CLK_HZ    (CLK_HZ),
    .TURN_SECS (TURN_SECS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  tests;
  int  fails;
  int  rej_cnt;
  wr_t exp_q[$];

  int h[7];
  bit m_turn;
  int m_moves;
  bit m_active;
  bit m_full;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample at the negedge, return just after the next rising edge.
  task automatic step();
    wr_t e;
    @(negedge clk);
    if (bus_if.reject) rej_cnt++;
    if (bus_if.wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected wr_en", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_row", int'(bus_if.wr_row), int'(e.row));
        chk("wr_col", int'(bus_if.wr_col), int'(e.col));
        chk("wr_val", int'(bus_if.wr_val), int'(e.val));
      end
    end else begin
      chk("idle write fields", int'({bus_if.wr_row, bus_if.wr_col, bus_if.wr_val}), 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bit p, input logic [2:0] c, input int kind, input logic [2:0] row,
                       input logic [1:0] val, input bit exp_turn, input bit exp_full);
    int r0;
    r0 = rej_cnt;
    if (kind == KW) exp_q.push_back('{row: row, col: c, val: val});
    if (p) begin
      bus_if.ard_req = 1'b1;
      bus_if.ard_col = c;
    end else begin
      bus_if.fpga_req = 1'b1;
      bus_if.fpga_col = c;
    end
    step();
    bus_if.fpga_req = 1'b0;
    bus_if.ard_req  = 1'b0;
    repeat (3) step();
    chk("reject pulses", rej_cnt - r0, (kind == KR) ? 1 : 0);
    chk("pending writes", exp_q.size(), 0);
    exp_q.delete();
    chk("turn", int'(bus_if.turn), int'(exp_turn));
    chk("board_full", int'(bus_if.board_full), int'(exp_full));
    if (kind == KW && !exp_full) chk("secs reload", int'(bus_if.secs_left), TURN_SECS);
  endtask

  task automatic move_model(input bit p, input logic [2:0] c);
    int         kind;
    logic [2:0] row;
    logic [1:0] val;
    row = '0;
    val = '0;
    if (!m_active || p != m_turn) kind = KI;
    else if (c >= 3'd7 || h[c] == 6) kind = KR;
    else kind = KW;
    if (kind == KW) begin
      row = 3'(h[c]);
      val = m_turn ? 2'b10 : 2'b01;
      h[c]++;
      m_moves++;
      if (m_moves == 42) begin
        m_active = 1'b0;
        m_full   = 1'b1;
      end else begin
        m_turn = ~m_turn;
      end
    end
    apply(p, c, kind, row, val, m_turn, m_full);
  endtask

  task automatic start_game(input bit fp);
    bus_if.start        = 1'b1;
    bus_if.first_player = fp;
    step();
    bus_if.start = 1'b0;
    for (int i = 0; i < 7; i++) h[i] = 0;
    m_turn   = fp;
    m_moves  = 0;
    m_active = 1'b1;
    m_full   = 1'b0;
    chk("start turn", int'(bus_if.turn), int'(fp));
    chk("start secs", int'(bus_if.secs_left), TURN_SECS);
    chk("start board_full", int'(bus_if.board_full), 0);
  endtask

  vec_t tbl[12];

  initial begin
    int cnt;
    bit t0;
    tests   = 0;
    fails   = 0;
    rej_cnt = 0;
    tbl[0]  = '{0, 3'd3, KW, 3'd0, 2'b01, 1'b1};
    tbl[1]  = '{0, 3'd2, KI, 3'd0, 2'b00, 1'b1};
    tbl[2]  = '{1, 3'd0, KW, 3'd0, 2'b10, 1'b0};
    tbl[3]  = '{1, 3'd2, KI, 3'd0, 2'b00, 1'b0};
    tbl[4]  = '{0, 3'd7, KR, 3'd0, 2'b00, 1'b0};
    tbl[5]  = '{0, 3'd0, KW, 3'd1, 2'b01, 1'b1};
    tbl[6]  = '{1, 3'd0, KW, 3'd2, 2'b10, 1'b0};
    tbl[7]  = '{0, 3'd0, KW, 3'd3, 2'b01, 1'b1};
    tbl[8]  = '{1, 3'd0, KW, 3'd4, 2'b10, 1'b0};
    tbl[9]  = '{0, 3'd0, KW, 3'd5, 2'b01, 1'b1};
    tbl[10] = '{1, 3'd0, KR, 3'd0, 2'b00, 1'b1};
    tbl[11] = '{1, 3'd5, KW, 3'd0, 2'b10, 1'b0};

    rst                 = 1'b0;
    bus_if.start        = 1'b0;
    bus_if.first_player = 1'b0;
    bus_if.fpga_req     = 1'b0;
    bus_if.fpga_col     = '0;
    bus_if.ard_req      = 1'b0;
    bus_if.ard_col      = '0;
    for (int i = 0; i < 7; i++) h[i] = 0;
    m_turn   = 1'b0;
    m_moves  = 0;
    m_active = 1'b0;
    m_full   = 1'b0;
    #1;
    chk("reset wr_en", int'(bus_if.wr_en), 0);
    chk("reset turn", int'(bus_if.turn), 0);
    chk("reset secs", int'(bus_if.secs_left), 0);
    chk("reset reject/full", int'({bus_if.reject, bus_if.board_full}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) step();

    // Release of reset alone must not start a game.
    move_model(1'b0, 3'd3);
    chk("idle secs", int'(bus_if.secs_left), 0);

    start_game(1'b0);
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].p, tbl[i].col, tbl[i].kind, tbl[i].row, tbl[i].val, tbl[i].turn_after, 1'b0);
      if (tbl[i].kind == KW) begin
        h[tbl[i].col]++;
        m_moves++;
      end
      m_turn = tbl[i].turn_after;
    end

    // A reject must not reload the turn timer.
    repeat (20) step();
    chk("secs after wait", int'(bus_if.secs_left), 1);
    move_model(1'b0, 3'd0);
    chk("secs after reject", int'(bus_if.secs_left), 1);
    move_model(1'b0, 3'd1);
    while (h[1] < 6) move_model(m_turn, 3'd1);

    // Timeout with columns 0 and 1 full.
    t0 = m_turn;
`ifdef AUTO_MOVE_EN
    exp_q.push_back('{row: 3'(h[2]), col: 3'd2, val: (t0 ? 2'b10 : 2'b01)});
    h[2]++;
    m_moves++;
`endif
    m_turn = ~t0;
    cnt = 0;
    while (bus_if.turn == t0 && cnt < 80) begin
      step();
      cnt++;
    end
    chk("timeout turn", int'(bus_if.turn), int'(m_turn));
    chk("timeout latency in range", int'(cnt >= 30 && cnt <= 40), 1);
    repeat (2) step();
    chk("timeout pending writes", exp_q.size(), 0);
    exp_q.delete();
    chk("timeout secs reload", int'(bus_if.secs_left), TURN_SECS);

    // Fill the rest of the board.
    for (int c = 0; c < 7; c++) begin
      while (h[c] < 6) move_model(m_turn, 3'(c));
    end
    chk("move count at full", m_moves, 42);
    move_model(1'b0, 3'd3);
    move_model(1'b1, 3'd3);
    chk("full holds", int'(bus_if.board_full), 1);

    start_game(1'b1);
    move_model(1'b1, 3'd0);
    move_model(1'b0, 3'd0);

    // Reset asserted during the WRITE cycle.
    bus_if.fpga_req = 1'b0;
    bus_if.ard_req  = 1'b1;
    bus_if.ard_col  = 3'd4;
    step();
    bus_if.ard_req = 1'b0;
    step();
    chk("wr_en before reset", int'(bus_if.wr_en), 1);
    rst = 1'b0;
    #1;
    chk("async reset wr_en", int'(bus_if.wr_en), 0);
    chk("async reset wr fields", int'({bus_if.wr_row, bus_if.wr_col, bus_if.wr_val}), 0);
    chk("async reset turn/secs", int'({bus_if.turn, bus_if.secs_left}), 0);
    chk("async reset reject/full", int'({bus_if.reject, bus_if.board_full}), 0);
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < 7; i++) h[i] = 0;
    m_turn   = 1'b0;
    m_moves  = 0;
    m_active = 1'b0;
    m_full   = 1'b0;
    repeat (10) step();
    chk("post-reset secs", int'(bus_if.secs_left), 0);
    move_model(1'b0, 3'd1);
    start_game(1'b0);
    move_model(1'b0, 3'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
